// File: rtl/casez_dispatch_pkg.sv
// Shared types and helpers for the casez dispatch sequencer and its matcher.
//   state_t     : sequencer state encoding
//   slot_lsb()  : low bit of slot k inside a flattened N*W pattern bus
//   IDXW        : match index width for the default slot count
package casez_dispatch_pkg;

    localparam int unsigned N_DEFAULT = 3;
    localparam int unsigned IDXW      = $clog2(N_DEFAULT + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EVAL = 3'd1,
        ST_PRE  = 3'd2,
        ST_POST = 3'd3,
        ST_DEF  = 3'd4
    } state_t;

    // Slot k of a flattened bus lives at [slot_lsb(k, w) +: w].
    function automatic int unsigned slot_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/casez_match_unit.sv
// Combinational priority wildcard matcher.
//   value, dc         : word to classify and its per-bit don't-care mask
//   pat_value/pat_care: N flattened W-bit slots; care=0 marks a wildcard bit
//   hit_c             : some slot matched
//   idx_c             : lowest matching slot, or N when nothing matched
module casez_match_unit
    import casez_dispatch_pkg::*;
#(
    parameter int unsigned W = 4,
    parameter int unsigned N = 3
) (
    input  logic [W-1:0]             value,
    input  logic [W-1:0]             dc,
    input  logic [N*W-1:0]           pat_value,
    input  logic [N*W-1:0]           pat_care,
    output logic                     hit_c,
    output logic [$clog2(N+1)-1:0]   idx_c
);

    localparam int unsigned IDXW_L = $clog2(N + 1);

    logic [N-1:0] slot_ok;

    // A bit matches when it is a wildcard, an input don't-care, or equal.
    always_comb begin
        slot_ok = '0;
        for (int unsigned k = 0; k < N; k++) begin
            slot_ok[k] = &(~pat_care[slot_lsb(k, W) +: W] | dc |
                           ~(value ^ pat_value[slot_lsb(k, W) +: W]));
        end
    end

    // Lowest-numbered matching slot wins.
    always_comb begin
        hit_c = 1'b0;
        idx_c = IDXW_L'(N);
        for (int unsigned k = 0; k < N; k++) begin
            if (!hit_c && slot_ok[k]) begin
                hit_c = 1'b1;
                idx_c = IDXW_L'(k);
            end
        end
    end

endmodule

// File: rtl/casez_dispatch_seq.sv
// Clocked wildcard dispatcher: accepts one word per handshake, matches it
// against N programmable casez-style patterns (first match wins), then
// writes the winning slot's result after a pre-dwell and waits a post-dwell;
// unmatched words take a shorter default path that pulses default_hit.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake (ready only while idle)
//   in_value, in_dc     : word to classify and its input-side don't-care mask
//   pat_value/care/result : N flattened W-bit pattern slots
//   out_value, out_valid: last written result and its one-cycle update pulse
//   match_idx           : matched slot (N = default), valid while busy
//   default_hit         : one-cycle pulse at the end of the default path
//   busy                : transaction in flight
//   txn_cnt             : saturating count of completed transactions
module casez_dispatch_seq
    import casez_dispatch_pkg::*;
#(
    parameter int unsigned W        = 4,
    parameter int unsigned N        = 3,
    parameter int unsigned PRE_CYC  = 3,
    parameter int unsigned POST_CYC = 3,
    parameter int unsigned DEF_CYC  = 2,
    parameter int unsigned ZSYM     = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_value,
    input  logic [W-1:0]           in_dc,
    input  logic [N*W-1:0]         pat_value,
    input  logic [N*W-1:0]         pat_care,
    input  logic [N*W-1:0]         pat_result,
    output logic [W-1:0]           out_value,
    output logic                   out_valid,
    output logic [$clog2(N+1)-1:0] match_idx,
    output logic                   default_hit,
    output logic                   busy,
    output logic [15:0]            txn_cnt
);

    localparam int unsigned IDXW_L = $clog2(N + 1);
    localparam int unsigned MAX_AB = (PRE_CYC > POST_CYC) ? PRE_CYC : POST_CYC;
    localparam int unsigned MAXC   = (MAX_AB > DEF_CYC) ? MAX_AB : DEF_CYC;
    localparam int unsigned CNTW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_t              state_q, state_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]        val_q, val_d;
    logic [W-1:0]        dc_q, dc_d;
    logic [W-1:0]        held_q, held_d;

    logic                in_ready_d;
    logic [W-1:0]        out_value_d;
    logic                out_valid_d;
    logic [IDXW_L-1:0]   match_idx_d;
    logic                default_hit_d;
    logic                busy_d;
    logic [15:0]         txn_cnt_d;
    logic [15:0]         txn_inc_c;

    logic                hit_c;
    logic [IDXW_L-1:0]   hit_idx_c;
    logic [W-1:0]        hit_res_c;

    // Matcher sees the captured word and the live pattern ports.
    casez_match_unit #(
        .W (W),
        .N (N)
    ) u_match (
        .value     (val_q),
        .dc        (dc_q),
        .pat_value (pat_value),
        .pat_care  (pat_care),
        .hit_c     (hit_c),
        .idx_c     (hit_idx_c)
    );

    // Result word of the winning slot; don't-care when nothing matched.
    always_comb begin
        hit_res_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (hit_idx_c == IDXW_L'(k)) begin
                hit_res_c = pat_result[slot_lsb(k, W) +: W];
            end
        end
    end

    assign txn_inc_c = (txn_cnt == 16'hFFFF) ? txn_cnt : txn_cnt + 16'd1;

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        val_d         = val_q;
        dc_d          = dc_q;
        held_d        = held_q;
        out_value_d   = out_value;
        out_valid_d   = 1'b0;
        match_idx_d   = match_idx;
        default_hit_d = 1'b0;
        txn_cnt_d     = txn_cnt;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    val_d   = in_value;
                    dc_d    = (ZSYM != 0) ? in_dc : '0;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                match_idx_d = hit_idx_c;
                cnt_d       = '0;
                if (hit_c) begin
                    held_d  = hit_res_c;
                    state_d = ST_PRE;
                end else begin
                    state_d = ST_DEF;
                end
            end
            ST_PRE: begin
                if (cnt_q == CNTW'(PRE_CYC - 1)) begin
                    out_value_d = held_q;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_POST;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_POST: begin
                if (cnt_q == CNTW'(POST_CYC - 1)) begin
                    txn_cnt_d = txn_inc_c;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_DEF: begin
                if (cnt_q == CNTW'(DEF_CYC - 1)) begin
                    default_hit_d = 1'b1;
                    txn_cnt_d     = txn_inc_c;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags follow the state being entered so they are registered.
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            val_q       <= '0;
            dc_q        <= '0;
            held_q      <= '0;
            in_ready    <= 1'b1;
            out_value   <= '0;
            out_valid   <= 1'b0;
            match_idx   <= '0;
            default_hit <= 1'b0;
            busy        <= 1'b0;
            txn_cnt     <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            val_q       <= val_d;
            dc_q        <= dc_d;
            held_q      <= held_d;
            in_ready    <= in_ready_d;
            out_value   <= out_value_d;
            out_valid   <= out_valid_d;
            match_idx   <= match_idx_d;
            default_hit <= default_hit_d;
            busy        <= busy_d;
            txn_cnt     <= txn_cnt_d;
        end
    end

endmodule
